countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clk cycles per one-second decrement tick.
REQ-002 Parameter BLANK_LZ, default 1, blanks the tens digit when tens==0 (1=blank, 0=show "0").
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  one-cycle pulse: load start_val into the counter and enter IDLE.
REQ-006 start  input  1  one-cycle pulse: begin or resume the countdown.
REQ-007 pause  input  1  one-cycle pulse: freeze the countdown.
REQ-008 start_val  input  7  binary preset, 0-99; values above 99 are clamped to 99.
REQ-009 segval_t  output  7  tens-digit segment pattern, bit0=a..bit6=g, active-low.
REQ-010 segval_u  output  7  units-digit segment pattern, same encoding.
REQ-011 running  output  1  high while state==RUN.
REQ-012 expired  output  1  level, high while state==DONE.
REQ-013 expire_pulse  output  1  single-cycle strobe on the cycle DONE is entered.

Function
REQ-014 The count SHALL be held as two BCD nibbles, tens and units, each 0-9.
REQ-015 FSM states SHALL be IDLE, RUN, PAUSED and DONE.
REQ-016 Command priority SHALL be load > start > pause when pulses coincide.
REQ-017 load from any state SHALL set tens/units = clamp(start_val) converted to BCD, clear the prescaler, and go to IDLE.
REQ-018 start in IDLE or PAUSED SHALL go to RUN; in IDLE it also clears the prescaler; in RUN or DONE it is ignored.
REQ-019 pause in RUN SHALL go to PAUSED and retain the prescaler value; it is ignored in other states.
REQ-020 Prescaler behaviour:
- Counts 0..TICK_DIV-1 only in RUN.
- A tick is asserted on the cycle the prescaler equals TICK_DIV-1, and the prescaler then wraps to 0.
REQ-021 Tick decrement behaviour:
- units>0: units-1.
- units==0, tens>0: units=9, tens-1.
- Resulting count 00: next state DONE.
REQ-022 start in IDLE with count 00 SHALL go directly to DONE, not RUN.
REQ-023 expire_pulse SHALL be high for exactly one cycle, on the first cycle state==DONE.
REQ-024 DONE SHALL hold count 00 until load.
REQ-025 segval_t and segval_u SHALL be registered: they reflect the count one clk cycle after it changes.
REQ-026 Decode patterns (active-low, "-" order g..a):
- 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Blank = 7'h7F.
REQ-027 With BLANK_LZ=1 and tens==0, segval_t SHALL be 7'h7F; units is never blanked.
REQ-028 running and expired SHALL be registered decodes of the state, never both high.

Reset
REQ-029 When rst_n is low, the block SHALL immediately set the following:
- state=IDLE, prescaler=0, tens=0, units=0.
- segval_t = 7'h7F if BLANK_LZ else 7'h40; segval_u = 7'h40.
- running=0, expired=0, expire_pulse=0.
REQ-030 A reset asserted mid-countdown SHALL abort without expire_pulse; release requires load before a meaningful start.

Structure
REQ-031 A shared package deadline_pkg SHALL hold the following:
- The state encoding (IDLE=0, RUN=1, PAUSED=2, DONE=3).
- The ten digit segment constants and SEG_BLANK.
REQ-032 Sub-module seg7_decode (4-bit BCD in, 7-bit active-low pattern out, combinational) SHALL be instantiated twice.
REQ-033 The outputs feed the downstream digit multiplexer directly: segval_t to the tens input and segval_u to the units input.

Verification (TICK_DIV=4)
REQ-034 load start_val=12, start -> after 4 clks units=1 (segval_u=7'h79), after 8 clks count 10, after 12 clks 09 with segval_t=7'h7F.
REQ-035 load 3, start -> expire_pulse high exactly once, 12 clks after start; expired stays high and running=0.
REQ-036 load 20, start, pause after 6 clks, hold 20 clks, start -> the next tick occurs 2 clks after resume and the count reads 18.
REQ-037 load start_val=120 -> count 99, segval_t=7'h10, segval_u=7'h10; load+start same cycle -> IDLE, count reloaded.
REQ-038 load 0, start -> DONE next cycle with one expire_pulse; rst_n low mid-RUN -> all outputs at reset values, no expire_pulse.

Source files
------------

// File: rtl/deadline_pkg.sv
// deadline_pkg: shared FSM encoding, seven-segment patterns and the preset-to-BCD helper
package deadline_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Presets above 99 saturate; result is {tens, units}
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] c;
        c = v > 7'd99 ? 7'd99 : v;
        return {4'(c / 7'd10), 4'(c % 7'd10)};
    endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low seven-segment pattern (bit0=a .. bit6=g)
module seg7_decode
    import deadline_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = bcd == 4'd0 ? SEG_0 :
              bcd == 4'd1 ? SEG_1 :
              bcd == 4'd2 ? SEG_2 :
              bcd == 4'd3 ? SEG_3 :
              bcd == 4'd4 ? SEG_4 :
              bcd == 4'd5 ? SEG_5 :
              bcd == 4'd6 ? SEG_6 :
              bcd == 4'd7 ? SEG_7 :
              bcd == 4'd8 ? SEG_8 :
              bcd == 4'd9 ? SEG_9 : SEG_BLANK;
    end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: two-digit BCD seconds countdown with load/start/pause control
// and registered seven-segment, running and expiry outputs.
module countdown_timer
    import deadline_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [6:0] start_val,
    output logic [6:0] segval_t,
    output logic [6:0] segval_u,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    state_t state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [3:0] tens, units, tens_n, units_n;
    logic [6:0] seg_t, seg_u;
    logic tick;
    always_comb begin
        tick = state == RUN && presc == PW'(TICK_DIV - 1);
        presc_n = state == RUN ? (tick ? '0 : presc + 1'b1) : presc;
        tens_n = tens;
        units_n = units;
        state_n = state;
        if (load) begin
            {tens_n, units_n} = to_bcd(start_val);
            presc_n = '0;
            state_n = IDLE;
        end else if (start && state == IDLE) begin
            presc_n = '0;
            state_n = {tens, units} == 8'd0 ? DONE : RUN;
        end else if (start && state == PAUSED) begin
            state_n = RUN;
        end else begin
            if (tick) begin
                units_n = units == 4'd0 ? 4'd9 : units - 4'd1;
                tens_n = units == 4'd0 ? tens - 4'd1 : tens;
            end
            // Reaching zero wins over a coincident pause
            if (tick && {tens_n, units_n} == 8'd0)
                state_n = DONE;
            else if (pause && state == RUN)
                state_n = PAUSED;
        end
    end
    seg7_decode u_dec_t (.bcd(tens), .seg(seg_t));
    seg7_decode u_dec_u (.bcd(units), .seg(seg_u));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
            tens <= '0;
            units <= '0;
            segval_t <= BLANK_LZ != 0 ? SEG_BLANK : SEG_0;
            segval_u <= SEG_0;
            running <= 1'b0;
            expired <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            tens <= tens_n;
            units <= units_n;
            segval_t <= BLANK_LZ != 0 && tens == 4'd0 ? SEG_BLANK : seg_t;
            segval_u <= seg_u;
            running <= state_n == RUN;
            expired <= state_n == DONE;
            expire_pulse <= state_n == DONE && state != DONE;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: randomized and directed stimulus against an integer-count
// reference model, with a queue-based scoreboard checked every falling edge.
module tb_countdown_timer;
    localparam int TD = 4;
    localparam int BL = 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [6:0] start_val = '0;
    logic [6:0] segval_t, segval_u;
    logic running, expired, expire_pulse;
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    string nq[$];
    logic [16:0] vq[$];
    int checks = 0, errors = 0;
    int m_cnt = 0, m_ph = 0, m_mode = M_IDLE;

    countdown_timer #(.TICK_DIV(TD), .BLANK_LZ(BL)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .start(start), .pause(pause),
        .start_val(start_val), .segval_t(segval_t), .segval_u(segval_u),
        .running(running), .expired(expired), .expire_pulse(expire_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input bit l, input bit s, input bit p, input int v);
        int pc, pm;
        bit tk;
        pc = m_cnt;
        pm = m_mode;
        tk = m_mode == M_RUN && m_ph == TD - 1;
        if (m_mode == M_RUN) m_ph = tk ? 0 : m_ph + 1;
        if (l) begin
            m_cnt = v > 99 ? 99 : v;
            m_ph = 0;
            m_mode = M_IDLE;
        end else if (s && m_mode == M_IDLE) begin
            m_ph = 0;
            m_mode = m_cnt == 0 ? M_DONE : M_RUN;
        end else if (s && m_mode == M_PAUSED) begin
            m_mode = M_RUN;
        end else begin
            if (tk) m_cnt = m_cnt - 1;
            if (tk && m_cnt == 0) m_mode = M_DONE;
            else if (p && m_mode == M_RUN) m_mode = M_PAUSED;
        end
        return {(BL != 0 && pc / 10 == 0) ? 7'h7F : seg_tbl[pc / 10], seg_tbl[pc % 10],
                m_mode == M_RUN, m_mode == M_DONE, m_mode == M_DONE && pm != M_DONE};
    endfunction

    task automatic step(input bit l, input bit s, input bit p, input int v, input string nm);
        load = l;
        start = s;
        pause = p;
        start_val = 7'(v);
        @(posedge clk);
        vq.push_back(model(l, s, p, v));
        nq.push_back(nm);
        #1;
        load = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, nm);
    endtask

    task automatic do_reset(input int n);
        #1;
        rst_n = 1'b0;
        nq.delete();
        vq.delete();
        m_cnt = 0;
        m_ph = 0;
        m_mode = M_IDLE;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [16:0] act, exp_v;
        string nm;
        act = {segval_t, segval_u, running, expired, expire_pulse};
        if (!rst_n) begin
            nm = "reset";
            exp_v = {BL != 0 ? 7'h7F : 7'h40, 7'h40, 3'b000};
        end else if (vq.size() > 0) begin
            nm = nq.pop_front();
            exp_v = vq.pop_front();
        end else begin
            nm = "";
            exp_v = act;
        end
        if (nm != "") begin
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s: got t=%h u=%h run=%b exp=%b pulse=%b, want t=%h u=%h run=%b exp=%b pulse=%b",
                         nm, act[16:10], act[9:3], act[2], act[1], act[0],
                         exp_v[16:10], exp_v[9:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({segval_t, segval_u, running, expired, expire_pulse} !== {BL != 0 ? 7'h7F : 7'h40, 7'h40, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: t=%h u=%h run=%b exp=%b pulse=%b",
                     segval_t, segval_u, running, expired, expire_pulse);
        end
        rst_n = 1'b1;
        step(1, 0, 0, 12, "load12");
        step(0, 1, 0, 0, "start12");
        idle(14, "count12");
        step(1, 0, 0, 3, "load3");
        step(0, 1, 0, 0, "start3");
        idle(16, "expire3");
        checks++;
        if (expired !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL expired_wait: expired=%b running=%b", expired, running);
        end
        step(1, 0, 0, 20, "load20");
        step(0, 1, 0, 0, "start20");
        idle(5, "run20");
        step(0, 0, 1, 0, "pause20");
        idle(20, "hold20");
        step(0, 1, 0, 0, "resume20");
        idle(6, "after_resume");
        step(1, 0, 0, 120, "clamp120");
        idle(2, "clamp_hold");
        step(0, 1, 0, 0, "start99");
        idle(3, "run99");
        step(1, 1, 0, 55, "load_start");
        idle(3, "load_prio");
        step(1, 0, 0, 0, "load0");
        step(0, 1, 0, 0, "start0");
        idle(3, "done0");
        step(1, 0, 0, 50, "load50");
        step(0, 1, 0, 0, "start50");
        idle(6, "run50");
        do_reset(3);
        idle(3, "post_reset");
        step(1, 0, 0, 2, "load2");
        step(0, 1, 0, 0, "start2");
        idle(10, "expire2");
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                step(r < 3, r >= 3 && r < 12, r >= 12 && r < 17,
                     int'($urandom_range(0, 127)), "random");
            end
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
